// File: rtl/alu_operand_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : alu_operand_loader                                               |
// | Brief    : Collects one command plus a serial operand stream, commits all   |
// |            five operand registers at once, then pulses the ALU start.       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module alu_operand_loader #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic                      cmd_f_add,
    output logic                      cmd_ready,
    input  logic [BUS_WIDTH-1:0]      bus_data,
    input  logic                      bus_valid,
    output logic                      bus_ready,
    output logic [4:0][BUS_WIDTH-1:0] ops,
    output logic [BUS_WIDTH-1:0]      op_e,
    output logic [4:0]                reg_en,
    output logic                      f_add,
    output logic                      alu_go,
    output logic                      busy
);

    localparam int         c_NUM_SLOTS   = 5;
    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_LOAD        = 2'd1;
    localparam logic [1:0] c_COMMIT      = 2'd2;
    localparam logic [1:0] c_GO          = 2'd3;
    localparam logic [2:0] c_LAST_NORMAL = 3'd4;
    localparam logic [2:0] c_LAST_ADD    = 3'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [2:0]             r_cnt;
    logic                   r_f_add;
    logic [BUS_WIDTH-1:0]   r_stage [c_NUM_SLOTS];
    logic                   w_cmd_fire;
    logic                   w_beat_fire;
    logic                   w_last_beat;
    logic [2:0]             w_slot_idx;
    logic [c_NUM_SLOTS-1:0] w_slot_sel;

    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_beat_fire = bus_valid && bus_ready;
    assign w_last_beat = w_beat_fire &&
                         (r_cnt == (r_f_add ? c_LAST_ADD : c_LAST_NORMAL));

    // Add mode fills a, c, e only, so beat k lands in slot 2k.
    assign w_slot_idx = r_f_add ? {r_cnt[1:0], 1'b0} : r_cnt;

    // Slot 4 is operand e; it is also visible as ops[4].
    for (genvar g = 0; g < c_NUM_SLOTS; g++) begin : g_slot
        assign w_slot_sel[g] = (w_slot_idx == 3'(g));
        assign ops[g]        = r_stage[g];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_cmd_fire)  w_state_nxt = c_LOAD;
            c_LOAD:   if (w_last_beat) w_state_nxt = c_COMMIT;
            c_COMMIT: w_state_nxt = c_GO;
            c_GO:     w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
            r_f_add <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_f_add <= cmd_f_add;
                r_cnt   <= 3'd0;
            end else if (w_beat_fire) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Clearing on command accept is what zeroes b and d in add mode.
    always_ff @(posedge clk) begin
        if (rst || w_cmd_fire) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_stage[i] <= '0;
            end
        end else if (w_beat_fire) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                if (w_slot_sel[i]) begin
                    r_stage[i] <= bus_data;
                end
            end
        end
    end

    assign cmd_ready = (r_state == c_IDLE);
    assign bus_ready = (r_state == c_LOAD);
    assign busy      = (r_state != c_IDLE);
    assign alu_go    = (r_state == c_GO);
    assign reg_en    = {c_NUM_SLOTS{r_state == c_COMMIT}};
    assign f_add     = r_f_add;
    assign op_e      = r_stage[4];

endmodule
`default_nettype wire
